// File: rtl/core_pkg.sv
// core_pkg: shared register-address types and the per-stage tracking record
// for the 8-register, 5-stage core.
package core_pkg;

  localparam int REG_AW = 3;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Per-stage record; EX carries every field, later stages a subset.
  typedef struct packed {
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      regwrite;
    logic      memread;
  } stage_t;

  localparam stage_t STAGE_NOP = '0;

  // A producer rd hits the ID sources; register 0 never counts as a producer.
  function automatic logic src_match(reg_addr_t prod_rd, reg_addr_t rs1,
                                     reg_addr_t rs2, logic uses_rs2);
    return (prod_rd != '0) && ((prod_rd == rs1) || (uses_rs2 && (prod_rd == rs2)));
  endfunction

endpackage

// File: rtl/hazard_track_if.sv
// hazard_track_if: ID-stage inputs, memory wait and the tracked/hazard outputs
// exchanged between the core pipeline (master) and hazard_track (slave).
interface hazard_track_if
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  reg_addr_t        rs1;
  reg_addr_t        rs2;
  reg_addr_t        rd;
  logic             RegWrite;
  logic             MemRead;
  logic             UsesRs2;
  logic             Branch;
  logic             mem_wait;

  reg_addr_t        rs1EX;
  reg_addr_t        rs2EX;
  reg_addr_t        rdEX;
  reg_addr_t        rdMEM;
  reg_addr_t        rdWB;
  logic             RegWriteEX;
  logic             RegWriteMEM;
  logic             RegWriteWB;
  logic             MemReadEX;
  logic             MemReadMEM;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rs1, rs2, rd, RegWrite, MemRead, UsesRs2, Branch, mem_wait,
    input  rs1EX, rs2EX, rdEX, rdMEM, rdWB,
    input  RegWriteEX, RegWriteMEM, RegWriteWB, MemReadEX, MemReadMEM,
    input  stall, bubble, stall_cycles
  );

  modport slave (
    input  rs1, rs2, rd, RegWrite, MemRead, UsesRs2, Branch, mem_wait,
    output rs1EX, rs2EX, rdEX, rdMEM, rdWB,
    output RegWriteEX, RegWriteMEM, RegWriteWB, MemReadEX, MemReadMEM,
    output stall, bubble, stall_cycles
  );

endinterface

// File: rtl/hazard_track_detect.sv
// hazard_detect: combinational load-use and branch-operand hazard terms.
// Optional macro BRANCH_STALL_EN enables the branch hazard; without it br_o=0.
module hazard_detect
  import core_pkg::*;
(
  input  stage_t    ex_i,
  input  reg_addr_t mem_rd_i,
  input  logic      mem_regwrite_i,
  input  logic      mem_memread_i,
  input  reg_addr_t rs1_i,
  input  reg_addr_t rs2_i,
  input  logic      uses_rs2_i,
  input  logic      branch_i,
  output logic      lu_o,
  output logic      br_o
);

  // A load in EX whose result an ID source needs cannot be forwarded in time.
  assign lu_o = ex_i.memread & ex_i.regwrite &
                src_match(ex_i.rd, rs1_i, rs2_i, uses_rs2_i);

`ifdef BRANCH_STALL_EN
  // Branches compare in ID: any producer in EX, or a load still in MEM, must
  // advance one more stage before its value can reach the comparator.
  assign br_o = branch_i &
                ((ex_i.regwrite & src_match(ex_i.rd, rs1_i, rs2_i, uses_rs2_i)) |
                 (mem_memread_i & mem_regwrite_i &
                  src_match(mem_rd_i, rs1_i, rs2_i, uses_rs2_i)));
`else
  // Branch operands are scheduled far enough from producers by the toolchain.
  assign br_o = 1'b0;
  wire unused_br_inputs = &{1'b0, branch_i, mem_rd_i, mem_regwrite_i, mem_memread_i};
`endif

endmodule

// File: rtl/hazard_track.sv
// hazard_track: EX/MEM/WB register-address tracker with load-use (and
// optional branch, macro BRANCH_STALL_EN) stall/bubble generation, a memory
// wait freeze and a saturating stall-cycle counter.
module hazard_track
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  hazard_track_if.slave  bus
);

  stage_t           ex_q, ex_d;
  reg_addr_t        mem_rd_q, mem_rd_d;
  logic             mem_rw_q, mem_rw_d;
  logic             mem_mr_q, mem_mr_d;
  reg_addr_t        wb_rd_q, wb_rd_d;
  logic             wb_rw_q, wb_rw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  stage_t           id_s;
  logic             lu, br;
  logic             stall_s, bubble_s;

  hazard_detect u_detect (
    .ex_i           (ex_q),
    .mem_rd_i       (mem_rd_q),
    .mem_regwrite_i (mem_rw_q),
    .mem_memread_i  (mem_mr_q),
    .rs1_i          (bus.rs1),
    .rs2_i          (bus.rs2),
    .uses_rs2_i     (bus.UsesRs2),
    .branch_i       (bus.Branch),
    .lu_o           (lu),
    .br_o           (br)
  );

  // Advance mode: freeze beats hazard bubble beats normal shift.
  always_comb begin
    id_s     = '{rs1: bus.rs1, rs2: bus.rs2, rd: bus.rd,
                 regwrite: bus.RegWrite, memread: bus.MemRead};
    ex_d     = ex_q;
    mem_rd_d = mem_rd_q;
    mem_rw_d = mem_rw_q;
    mem_mr_d = mem_mr_q;
    wb_rd_d  = wb_rd_q;
    wb_rw_d  = wb_rw_q;
    cnt_d    = cnt_q;
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    if (bus.mem_wait) begin
      stall_s = 1'b1;
    end else begin
      mem_rd_d = ex_q.rd;
      mem_rw_d = ex_q.regwrite;
      mem_mr_d = ex_q.memread;
      wb_rd_d  = mem_rd_q;
      wb_rw_d  = mem_rw_q;
      if (lu | br) begin
        stall_s  = 1'b1;
        bubble_s = 1'b1;
        ex_d     = STAGE_NOP;
      end else begin
        ex_d = id_s;
      end
    end
    if (stall_s && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stage registers and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= STAGE_NOP;
      mem_rd_q <= '0;
      mem_rw_q <= 1'b0;
      mem_mr_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_rw_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_rd_q <= mem_rd_d;
      mem_rw_q <= mem_rw_d;
      mem_mr_q <= mem_mr_d;
      wb_rd_q  <= wb_rd_d;
      wb_rw_q  <= wb_rw_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.rs1EX        = ex_q.rs1;
  assign bus.rs2EX        = ex_q.rs2;
  assign bus.rdEX         = ex_q.rd;
  assign bus.RegWriteEX   = ex_q.regwrite;
  assign bus.MemReadEX    = ex_q.memread;
  assign bus.rdMEM        = mem_rd_q;
  assign bus.RegWriteMEM  = mem_rw_q;
  assign bus.MemReadMEM   = mem_mr_q;
  assign bus.rdWB         = wb_rd_q;
  assign bus.RegWriteWB   = wb_rw_q;
  assign bus.stall        = stall_s;
  assign bus.bubble       = bubble_s;
  assign bus.stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_track.sv
// tb_hazard_track: directed per-cycle vectors; the driver queues the expected
// outputs for each cycle and a negedge monitor pops and compares them.
module tb_hazard_track;

`ifdef BRANCH_STALL_EN
  localparam int BR = 1;
`else
  localparam int BR = 0;
`endif

  typedef struct packed {
    logic       full;
    logic       stall;
    logic       bubble;
    logic [3:0] cnt;
    logic [2:0] rs1EX;
    logic [2:0] rs2EX;
    logic [2:0] rdEX;
    logic       rwEX;
    logic       mrEX;
    logic [2:0] rdMEM;
    logic       rwMEM;
    logic       mrMEM;
    logic [2:0] rdWB;
    logic       rwWB;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_push = 0;
  exp_t e_m, a_m;

  hazard_track_if #(.CNT_W(4)) bus ();

  hazard_track #(.CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t fe(int s, int b, int c, int r1x, int r2x, int rdx,
                              int rwx, int mrx, int rdm, int rwm, int mrm,
                              int rdw, int rww);
    exp_t e;
    e.full  = 1'b1;
    e.stall = s[0];  e.bubble = b[0];  e.cnt = c[3:0];
    e.rs1EX = r1x[2:0]; e.rs2EX = r2x[2:0]; e.rdEX = rdx[2:0];
    e.rwEX  = rwx[0];   e.mrEX  = mrx[0];
    e.rdMEM = rdm[2:0]; e.rwMEM = rwm[0];   e.mrMEM = mrm[0];
    e.rdWB  = rdw[2:0]; e.rwWB  = rww[0];
    return e;
  endfunction

  function automatic exp_t pe(int s, int b, int c);
    exp_t e;
    e = fe(s, b, c, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e.full = 1'b0;
    return e;
  endfunction

  task automatic step(input logic rst, input int r1, input int r2, input int d,
                      input logic rw, input logic mr, input logic u2,
                      input logic b, input logic mw, input exp_t e);
    @(posedge clk);
    #1;
    reset        = rst;
    bus.rs1      = r1[2:0];
    bus.rs2      = r2[2:0];
    bus.rd       = d[2:0];
    bus.RegWrite = rw;
    bus.MemRead  = mr;
    bus.UsesRs2  = u2;
    bus.Branch   = b;
    bus.mem_wait = mw;
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic nop(input exp_t e);
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);
  endtask

  // Monitor: one compare per queued cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_m = exp_q.pop_front();
      a_m.full  = e_m.full;
      a_m.stall = bus.stall;   a_m.bubble = bus.bubble; a_m.cnt = bus.stall_cycles;
      a_m.rs1EX = bus.rs1EX;   a_m.rs2EX  = bus.rs2EX;  a_m.rdEX = bus.rdEX;
      a_m.rwEX  = bus.RegWriteEX;  a_m.mrEX = bus.MemReadEX;
      a_m.rdMEM = bus.rdMEM;   a_m.rwMEM = bus.RegWriteMEM; a_m.mrMEM = bus.MemReadMEM;
      a_m.rdWB  = bus.rdWB;    a_m.rwWB  = bus.RegWriteWB;
      n_vec++;
      if (e_m.full ? (a_m !== e_m)
                   : ({a_m.stall, a_m.bubble, a_m.cnt} !== {e_m.stall, e_m.bubble, e_m.cnt})) begin
        n_bad++;
        $display("FAIL vec%0d: got %h want %h (full=%0d)", n_vec, a_m, e_m, e_m.full);
      end else begin
        $display("vec%0d ok: stall=%0d bubble=%0d cnt=%0d rdEX=%0d rdMEM=%0d rdWB=%0d",
                 n_vec, a_m.stall, a_m.bubble, a_m.cnt, a_m.rdEX, a_m.rdMEM, a_m.rdWB);
      end
    end
  end

  initial begin
    bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.RegWrite = 1'b0;
    bus.MemRead = 1'b0; bus.UsesRs2 = 1'b0; bus.Branch = 1'b0; bus.mem_wait = 1'b0;

    // Reset state, then idle cycles.
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, fe(0,0,0, 0,0,0,0,0, 0,0,0, 0,0));
    repeat (3) nop(fe(0,0,0, 0,0,0,0,0, 0,0,0, 0,0));

    // Load rd=3 then dependent add: one bubble.
    step(1'b0, 1, 0, 3, 1, 1, 0, 0, 0, fe(0,0,0, 0,0,0,0,0, 0,0,0, 0,0));
    step(1'b0, 3, 4, 6, 1, 0, 1, 0, 0, fe(1,1,0, 1,0,3,1,1, 0,0,0, 0,0));
    step(1'b0, 3, 4, 6, 1, 0, 1, 0, 0, fe(0,0,1, 0,0,0,0,0, 3,1,1, 0,0));
    nop(fe(0,0,1, 3,4,6,1,0, 0,0,0, 3,1));

    // Load rd=0 then consumer of r0: no stall.
    step(1'b0, 2, 0, 0, 1, 1, 0, 0, 0, fe(0,0,1, 0,0,0,0,0, 6,1,0, 0,0));
    step(1'b0, 0, 0, 1, 1, 0, 1, 0, 0, fe(0,0,1, 2,0,0,1,1, 0,0,0, 6,1));
    nop(fe(0,0,1, 0,0,1,1,0, 0,1,1, 0,0));
    nop(fe(0,0,1, 0,0,0,0,0, 1,1,0, 0,1));
    nop(fe(0,0,1, 0,0,0,0,0, 0,0,0, 1,1));

    // Load-use hazard under 3 cycles of mem_wait, then one bubble.
    step(1'b0, 0, 0, 2, 1, 1, 0, 0, 0, fe(0,0,1, 0,0,0,0,0, 0,0,0, 0,0));
    step(1'b0, 1, 2, 4, 1, 0, 1, 0, 1, fe(1,0,1, 0,0,2,1,1, 0,0,0, 0,0));
    step(1'b0, 1, 2, 4, 1, 0, 1, 0, 1, fe(1,0,2, 0,0,2,1,1, 0,0,0, 0,0));
    step(1'b0, 1, 2, 4, 1, 0, 1, 0, 1, fe(1,0,3, 0,0,2,1,1, 0,0,0, 0,0));
    step(1'b0, 1, 2, 4, 1, 0, 1, 0, 0, fe(1,1,4, 0,0,2,1,1, 0,0,0, 0,0));
    step(1'b0, 1, 2, 4, 1, 0, 1, 0, 0, fe(0,0,5, 0,0,0,0,0, 2,1,1, 0,0));
    nop(fe(0,0,5, 1,2,4,1,0, 0,0,0, 2,1));
    nop(fe(0,0,5, 0,0,0,0,0, 4,1,0, 0,0));
    nop(fe(0,0,5, 0,0,0,0,0, 0,0,0, 4,1));

    // Reset during a stall clears every stage and the counter.
    step(1'b0, 0, 0, 7, 1, 1, 0, 0, 0, fe(0,0,5, 0,0,0,0,0, 0,0,0, 0,0));
    step(1'b1, 7, 0, 1, 1, 0, 0, 0, 0, fe(1,1,5, 0,0,7,1,1, 0,0,0, 0,0));
    step(1'b0, 7, 0, 1, 1, 0, 0, 0, 0, fe(0,0,0, 0,0,0,0,0, 0,0,0, 0,0));
    nop(fe(0,0,0, 7,0,1,1,0, 0,0,0, 0,0));
    nop(fe(0,0,0, 0,0,0,0,0, 1,1,0, 0,0));
    nop(fe(0,0,0, 0,0,0,0,0, 0,0,0, 1,1));

    // ALU producer then branch: 1 stall only with the branch feature.
    step(1'b0, 1, 1, 5, 1, 0, 1, 0, 0, pe(0,0,0));
    step(1'b0, 5, 0, 0, 0, 0, 1, 1, 0, pe(BR,BR,0));
    step(1'b0, 5, 0, 0, 0, 0, 1, 1, 0, pe(0,0,BR));
    repeat (3) nop(pe(0,0,BR));

    // Load producer then branch: 2 stalls with the feature, 1 (load-use) without.
    step(1'b0, 1, 0, 5, 1, 1, 0, 0, 0, pe(0,0,BR));
    step(1'b0, 5, 0, 0, 0, 0, 1, 1, 0, pe(1,1,BR));
    step(1'b0, 5, 0, 0, 0, 0, 1, 1, 0, pe(BR,BR,BR+1));
    step(1'b0, 5, 0, 0, 0, 0, 1, 1, 0, pe(0,0,2*BR+1));
    repeat (3) nop(pe(0,0,2*BR+1));

    // Clear the counter, then hold stall for 2^4+5 cycles: saturates at 15.
    step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, pe(0,0,2*BR+1));
    for (int k = 0; k < 21; k++) begin
      step(1'b0, 0, 0, 0, 0, 0, 0, 0, 1,
           fe(1,0,(k > 15) ? 15 : k, 0,0,0,0,0, 0,0,0, 0,0));
    end
    nop(fe(0,0,15, 0,0,0,0,0, 0,0,0, 0,0));

    repeat (2) @(negedge clk);
    #1;
    if (n_vec != n_push) begin
      n_bad++;
      $display("FAIL drain: checked %0d, required %0d", n_vec, n_push);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
